// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, Q4.28 angle constants and FSM encoding for the cordic front end.
package cordic_pkg;
  localparam int N_DEF = 32;
  localparam int M_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam logic [31:0] PI = 32'h3243F6A9;
  localparam logic [31:0] HALF_PI = 32'h1921FB54;
  localparam logic [31:0] TWO_PI = 32'h6487ED51;
  typedef enum logic [2:0] {IDLE, REDUCE, FOLD, START, WAIT, DONE} state_t;
  // Rescales a 28-fraction-bit constant to fb fraction bits.
  function automatic logic [63:0] q_scale(input logic [63:0] c, input int fb);
    return fb >= 28 ? c << (fb - 28) : c >> (28 - fb);
  endfunction
endpackage

// File: rtl/cordic_angle_reduce.sv
// cordic_angle_reduce: one combinational wrap (fold=0) or fold (fold=1) step on an angle.
module cordic_angle_reduce
  import cordic_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int m = M_DEF
) (
  input  logic [n-1:0] z_in,
  input  logic         fold,
  output logic [n-1:0] z_out,
  output logic         neg
);
  localparam logic [n-1:0] PI_K = n'(q_scale(64'(PI), n - m));
  localparam logic [n-1:0] HALF_K = n'(q_scale(64'(HALF_PI), n - m));
  localparam logic [n-1:0] TWO_K = n'(q_scale(64'(TWO_PI), n - m));
  logic hi, lo;
  logic [n-1:0] step;
  always_comb begin
    hi = fold ? $signed(z_in) > $signed(HALF_K) : $signed(z_in) >= $signed(PI_K);
    lo = fold ? $signed(z_in) < -$signed(HALF_K) : $signed(z_in) < -$signed(PI_K);
    step = fold ? PI_K : TWO_K;
    z_out = hi ? z_in - step : lo ? z_in + step : z_in;
    neg = fold && (hi || lo);
  end
endmodule

// File: rtl/cordic_quadrant_ctrl.sv
// cordic_quadrant_ctrl: reduces an angle into [-pi/2, pi/2], sequences the cordic core and
// returns quadrant-corrected cos/sin, with a watchdog for a core that never finishes.
module cordic_quadrant_ctrl
  import cordic_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int m = M_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [n-1:0] angle_i,
  output logic         cordic_stc_o,
  output logic [n-1:0] cordic_z0_o,
  input  logic         cordic_eoc_i,
  input  logic [n-1:0] cordic_xn_i,
  input  logic [n-1:0] cordic_yn_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [n-1:0] cos_o,
  output logic [n-1:0] sin_o,
  output logic         err_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [n-1:0] z, z_red;
  logic neg, neg_red;
  logic [WW-1:0] wd;
  logic wd_done;
  function automatic logic [n-1:0] neg_sat(input logic [n-1:0] v);
    return v == {1'b1, {(n-1){1'b0}}} ? {1'b0, {(n-1){1'b1}}} : -v;
  endfunction
  cordic_angle_reduce #(.n(n), .m(m)) u_reduce (
    .z_in (z),
    .fold (state == FOLD),
    .z_out(z_red),
    .neg  (neg_red)
  );
  assign cordic_z0_o = z;
  assign wd_done = wd == WW'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = valid_i && ready_o ? REDUCE : IDLE;
      REDUCE:  state_nx = FOLD;
      FOLD:    state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    state_nx = cordic_eoc_i || wd_done ? DONE : WAIT;
      DONE:    state_nx = ready_i ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Handshake flags are registered copies of the next state so every output comes from a flop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      ready_o <= 1'b0;
      valid_o <= 1'b0;
      cordic_stc_o <= 1'b0;
      err_o <= 1'b0;
      cos_o <= '0;
      sin_o <= '0;
      z <= '0;
      neg <= 1'b0;
      wd <= '0;
    end else begin
      state <= state_nx;
      ready_o <= state_nx == IDLE;
      valid_o <= state_nx == DONE;
      cordic_stc_o <= state_nx == START;
      case (state)
        IDLE: if (valid_i && ready_o) z <= angle_i;
        REDUCE: z <= z_red;
        FOLD: begin
          z <= z_red;
          neg <= neg_red;
        end
        START: wd <= '0;
        WAIT: begin
          if (cordic_eoc_i) begin
            cos_o <= neg ? neg_sat(cordic_xn_i) : cordic_xn_i;
            sin_o <= neg ? neg_sat(cordic_yn_i) : cordic_yn_i;
            err_o <= 1'b0;
          end else if (wd_done) begin
            cos_o <= '0;
            sin_o <= '0;
            err_o <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_quadrant_ctrl.sv
// tb_cordic_quadrant_ctrl: directed and randomized transactions against a behavioural
// angle-reduction model, with the cordic core emulated cycle by cycle from the bench.
module tb_cordic_quadrant_ctrl;
  localparam longint PI = 64'sh3243F6A9;
  localparam longint HP = 64'sh1921FB54;
  localparam longint TP = 64'sh6487ED51;
  logic clk = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b0, cordic_eoc_i = 1'b0;
  logic [31:0] angle_i = '0, cordic_xn_i = '0, cordic_yn_i = '0;
  logic ready_o, cordic_stc_o, valid_o, err_o;
  logic [31:0] cordic_z0_o, cos_o, sin_o;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  cordic_quadrant_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .angle_i(angle_i),
    .cordic_stc_o(cordic_stc_o), .cordic_z0_o(cordic_z0_o), .cordic_eoc_i(cordic_eoc_i),
    .cordic_xn_i(cordic_xn_i), .cordic_yn_i(cordic_yn_i), .valid_o(valid_o), .ready_i(ready_i),
    .cos_o(cos_o), .sin_o(sin_o), .err_o(err_o)
  );

  function automatic void model(input logic [31:0] a, output logic [31:0] z, output bit neg);
    longint v;
    v = longint'($signed(a));
    while (v >= PI) v -= TP;
    while (v < -PI) v += TP;
    neg = 1'b0;
    if (v > HP) begin v -= PI; neg = 1'b1; end
    else if (v < -HP) begin v += PI; neg = 1'b1; end
    z = v[31:0];
  endfunction

  function automatic logic [31:0] fix(input bit neg, input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    if (neg) v = -v;
    if (v > 64'sh7FFFFFFF) v = 64'sh7FFFFFFF;
    return v[31:0];
  endfunction

  // lat > 63 means the emulated core never signals end of conversion.
  task automatic run_txn(input logic [31:0] a, input int lat, input logic [31:0] rx, input logic [31:0] ry,
                         input bit level, input int bp, input bit hold, input logic [31:0] nxt,
                         input logic [31:0] ez, input logic [31:0] ec, input logic [31:0] es, input bit ee);
    int w, exp_c;
    exp_c = lat > 63 ? 67 : 4 + lat;
    valid_i = 1'b1; angle_i = a; w = 0;
    while (!ready_o && w < 100) begin @(negedge clk); w++; end
    n_cmp++;
    if (!ready_o) begin
      n_bad++; $display("FAIL accept_wait: ready_o got %b want 1", ready_o);
      valid_i = 1'b0; return;
    end
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0; angle_i = $urandom;
    cordic_xn_i = rx; cordic_yn_i = ry;
    for (int c = 0; c < exp_c; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (cordic_stc_o !== (c == 2)) begin n_bad++; $display("FAIL stc c=%0d: got %b want %b", c, cordic_stc_o, c == 2); end
      n_cmp++;
      if (valid_o !== 1'b0 || ready_o !== 1'b0) begin n_bad++; $display("FAIL busy c=%0d: valid/ready got %b%b want 00", c, valid_o, ready_o); end
      if (c >= 2) begin
        n_cmp++;
        if (cordic_z0_o !== ez) begin n_bad++; $display("FAIL z0 c=%0d: got %h want %h", c, cordic_z0_o, ez); end
      end
      cordic_eoc_i = c < 3 ? 1'($urandom_range(0, 1)) : level ? (c >= 3 + lat) : (c == 3 + lat);
    end
    @(negedge clk);
    cordic_eoc_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin n_bad++; $display("FAIL done_flags: valid/ready got %b%b want 10", valid_o, ready_o); end
    n_cmp++;
    if (cos_o !== ec || sin_o !== es || err_o !== ee) begin
      n_bad++; $display("FAIL result a=%h: got cos %h sin %h err %b want %h %h %b", a, cos_o, sin_o, err_o, ec, es, ee);
    end
    if (hold) begin valid_i = 1'b1; angle_i = nxt; end
    repeat (bp) begin
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || cos_o !== ec || sin_o !== es || err_o !== ee) begin
        n_bad++; $display("FAIL hold: got v%b r%b %h %h %b want v1 r0 %h %h %b", valid_o, ready_o, cos_o, sin_o, err_o, ec, es, ee);
      end
      cordic_eoc_i = 1'($urandom_range(0, 1));
    end
    cordic_eoc_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    ready_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL release: valid/ready got %b%b want 01", valid_o, ready_o); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready_o, valid_o, cordic_stc_o, err_o} !== 4'b0 || cos_o !== 0 || sin_o !== 0 || cordic_z0_o !== 0) begin
      n_bad++; $display("FAIL reset_vals: got r%b v%b s%b e%b %h %h %h want all 0", ready_o, valid_o, cordic_stc_o, err_o, cos_o, sin_o, cordic_z0_o);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_vectors();
    run_txn(32'h14000000, 34, 32'h05000000, 32'h0F000000, 0, 1, 0, 0, 32'h14000000, 32'h05000000, 32'h0F000000, 0);
    run_txn(32'h28000000, 20, 32'h0A000000, 32'h04000000, 0, 2, 0, 0, 32'hF5BC0957, 32'hF6000000, 32'hFC000000, 0);
    run_txn(32'h50000000, 10, 32'h0B000000, 32'h02000000, 1, 0, 0, 0, 32'hEB7812AF, 32'h0B000000, 32'h02000000, 0);
  endtask

  task automatic test_saturate();
    run_txn(32'h28000000, 5, 32'h80000000, 32'h00000000, 0, 0, 0, 0, 32'hF5BC0957, 32'h7FFFFFFF, 32'h00000000, 0);
  endtask

  task automatic test_boundary();
    logic [31:0] pts [6];
    logic [31:0] z;
    bit ng;
    pts = '{32'h3243F6A9, 32'hCDBC0957, 32'h1921FB54, 32'hE6DE04AC, 32'h7FFFFFFF, 32'h80000000};
    foreach (pts[i]) begin
      model(pts[i], z, ng);
      run_txn(pts[i], 3 + i, 32'h12345678, 32'hEDCBA988, i[0], 0, 0, 0, z, fix(ng, 32'h12345678), fix(ng, 32'hEDCBA988), 0);
    end
  endtask

  task automatic test_timeout();
    run_txn(32'h14000000, 1000, 32'h11111111, 32'h22222222, 0, 3, 0, 0, 32'h14000000, 0, 0, 1);
    run_txn(32'h14000000, 63, 32'h01000000, 32'h02000000, 0, 0, 0, 0, 32'h14000000, 32'h01000000, 32'h02000000, 0);
  endtask

  task automatic test_back_to_back();
    run_txn(32'h28000000, 4, 32'h0A000000, 32'h04000000, 0, 10, 1, 32'h50000000, 32'hF5BC0957, 32'hF6000000, 32'hFC000000, 0);
    run_txn(32'h50000000, 4, 32'h0B000000, 32'h02000000, 0, 0, 0, 0, 32'hEB7812AF, 32'h0B000000, 32'h02000000, 0);
  endtask

  task automatic test_reset_mid_wait();
    int w = 0;
    valid_i = 1'b1; angle_i = 32'h28000000;
    while (!ready_o && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    repeat (8) @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    n_cmp++;
    if ({ready_o, valid_o, cordic_stc_o, err_o} !== 4'b0 || cos_o !== 0 || sin_o !== 0 || cordic_z0_o !== 0) begin
      n_bad++; $display("FAIL midreset_vals: got r%b v%b s%b e%b %h %h %h want all 0", ready_o, valid_o, cordic_stc_o, err_o, cos_o, sin_o, cordic_z0_o);
    end
    cordic_xn_i = 32'h0A000000; cordic_yn_i = 32'h04000000; cordic_eoc_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) cordic_eoc_i = 1'b0;
      n_cmp++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL stale_eoc i=%0d: valid/ready got %b%b want 01", i, valid_o, ready_o); end
    end
    run_txn(32'h14000000, 34, 32'h05000000, 32'h0F000000, 0, 1, 0, 0, 32'h14000000, 32'h05000000, 32'h0F000000, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, rx, ry, z;
    bit ng;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      rx = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
      ry = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
      model(a, z, ng);
      run_txn(a, $urandom_range(0, 40), rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0,
              z, fix(ng, rx), fix(ng, ry), 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vectors();
    test_saturate();
    test_boundary();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
